// File: rtl/ram_access_controller_if.sv
// Request/response handshake bundle between a requester and the RAM controller.
// master: requester side; slave: controller side.
interface ram_access_controller_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_write_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_read_data;
  logic                  rsp_error;

  modport master (
    output req_valid,
    output req_write,
    output req_address,
    output req_write_data,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_read_data,
    input  rsp_error
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_address,
    input  req_write_data,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_read_data,
    output rsp_error
  );
endinterface

// File: rtl/ram_access_controller.sv
// Single-outstanding load/store front end for a single-port word RAM.
// Ports: clk, reset (async, active-low), bus (req/rsp slave), ram_* RAM side.
module ram_access_controller #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h10010000
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_access_controller_if.slave bus,
  output logic                  ram_write_enable,
  output logic [DATA_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  localparam logic [DATA_WIDTH-1:0] DEPTH_W =
    DATA_WIDTH'(MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  write_q;
  logic                  error_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0] index;
  logic                  below_base;
  logic                  addr_err;
  logic                  accept;

  // Subtract only above the base so low addresses cannot
  // wrap around and alias into the RAM window.
  always_comb begin
    below_base = bus.req_address < BASE_ADDRESS;
    offset     = '0;
    if (!below_base) begin
      offset = bus.req_address - BASE_ADDRESS;
    end
    index    = offset >> 2;
    addr_err = (bus.req_address[1:0] != 2'b00) ||
               below_base ||
               (index >= DEPTH_W);
  end

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d          = state_q;
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    ram_write_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_d = addr_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        ram_write_enable = write_q;
        state_d          = write_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      error_q        <= 1'b0;
      rdata_q        <= '0;
      ram_address    <= '0;
      ram_write_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= bus.req_write;
        error_q <= addr_err;
        rdata_q <= '0;
        // RAM side only moves for requests that will access it.
        if (!addr_err) begin
          ram_address    <= index;
          ram_write_data <= bus.req_write_data;
        end
      end
      if (state_q == CAPTURE) begin
        rdata_q <= ram_read_data;
      end
    end
  end

  assign bus.rsp_read_data = rdata_q;
  assign bus.rsp_error     = error_q;

endmodule
